mult_div_32: RTL and testbench
==============================

// Module: mult_div_32
// PURPOSE
//  Iterative 32-bit multiply/divide unit with HI/LO registers, downstream of alu_32_control.
//  Executes MULT/MULTU/DIV/DIVU one bit per cycle and serves MFHI/MFLO/MTHI/MTLO.
//  busy stalls PC/register-file write in the otherwise single-cycle datapath.
// PARAMETERS
//  WIDTH   32  operand width; HI/LO are WIDTH each; iteration count = WIDTH
// PORTS
//  clk       in   1      rising-edge clock, single clock domain
//  rst_n     in   1      asynchronous active-low reset
//  start     in   1      launch op; sampled only in IDLE
//  op        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (= func[1:0])
//  src_a     in   WIDTH  rs operand (multiplicand / dividend)
//  src_b     in   WIDTH  rt operand (multiplier / divisor)
//  hi_we     in   1      MTHI: HI <= src_a
//  lo_we     in   1      MTLO: LO <= src_a
//  hi        out  WIDTH  HI register (MFHI source)
//  lo        out  WIDTH  LO register (MFLO source)
//  busy      out  1      operation in progress; processor must stall
//  done      out  1      one-cycle pulse: HI/LO just updated by an op
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, hi=lo=0, busy=0, done=0, counter=0, op aborted.
//  FSM IDLE -> RUN -> FIX -> IDLE. All outputs registered.
//  IDLE: start=1 at edge T latches op, |src_a|,|src_b| (abs only for signed ops), operand
//    signs; busy=1 from T. Else hi_we/lo_we update HI/LO at that edge.
//  RUN: one shift-add (mult) or restoring shift-subtract (div) step per edge; 5-bit counter
//    0..31; after step 31 (edge T+32) -> FIX.
//  FIX (edge T+33): sign correction, HI/LO written, done=1 for that cycle only, busy=0, -> IDLE.
//    Total: start accepted at T, done high in cycle after edge T+33 (33-cycle latency).
//  Mult: {HI,LO} = full 2*WIDTH product; signed product negated iff signs differ.
//  Div: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
//  Divide by zero: no trap; LO = 32'hFFFFFFFF, HI = src_a (both DIV and DIVU).
//  DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
//  start while busy: ignored, no re-latch. hi_we/lo_we while busy: ignored.
//  start together with hi_we/lo_we in IDLE: start wins, writes dropped.
//  Back-to-back: start may be reasserted in the cycle done=1 (state already IDLE).
//  HI/LO hold their values between ops; only op completion, MTHI/MTLO or reset change them.
// STRUCTURE
//  Shared header mips_defs.vh: func codes MULT 6'b011000, MULTU 6'b011001, DIV 6'b011010,
//    DIVU 6'b011011, MFHI 6'b010000, MTHI 6'b010001, MFLO 6'b010010, MTLO 6'b010011;
//    MDU op encodings; FSM state encodings (IDLE/RUN/FIX).
//  One sub-module: mdu_sign_adj (combinational abs-value / conditional negate, WIDTH
//    and 2*WIDTH instances) used at operand latch and in FIX.
//  Datapath: 2*WIDTH accumulator/remainder register, WIDTH shift register, counter.
// TESTING
//  MULTU FFFFFFFF*FFFFFFFF -> HI=FFFFFFFE, LO=00000001; busy 33 cycles; done exactly 1 cycle.
//  MULT FFFFFFFD(-3)*00000005 -> HI=FFFFFFFF, LO=FFFFFFF1; MULT 0*anything -> HI=LO=0.
//  DIV FFFFFFF9(-7)/00000002 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
//  DIVU 00000007/0 -> LO=FFFFFFFF, HI=00000007; DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
//  Start at cycle 5 of op, MTHI while busy -> ignored, first result intact; MTLO 1234 in
//    IDLE -> LO=00001234; start+MTHI same cycle -> only op result lands.
//  rst_n low at RUN cycle 10 -> hi=lo=0, busy=0, done=0 immediately (async); new op after
//    release completes with correct result.

Source files
------------

// File: rtl/mult_div_32_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - MIPS func codes for the HI/LO instruction group
//   - MDU op encodings (equal to func[1:0] of the MULT/DIV group)
//   - FSM state encodings
package mult_div_32_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_sign_adj.sv
// Combinational conditional negate. Used both as an absolute-value stage
// (neg = signed_op & msb) at operand latch and as the final sign correction.
// Ports:
//   val_in   in   W   value to adjust
//   neg      in   1   1: output two's-complement negation, 0: pass through
//   val_out  out  W   adjusted value
module mdu_sign_adj #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_in,
    input  logic         neg,
    output logic [W-1:0] val_out
);

    assign val_out = neg ? -val_in : val_in;

endmodule

// File: rtl/mult_div_32.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle
// on magnitudes; signs are reapplied in a final FIX cycle.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start, op        launch MULT/MULTU/DIV/DIVU (sampled in IDLE only)
//   src_a, src_b     rs / rt operands
//   hi_we, lo_we     MTHI / MTLO (write src_a, IDLE only, start has priority)
//   hi, lo           HI / LO registers
//   busy             op in flight, stall the pipeline
//   done             one-cycle pulse when HI/LO receive an op result
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO accepted
// RUN   | WIDTH iteration steps, counter 0..WIDTH-1
// FIX   | sign correction, HI/LO written, done pulse
module mult_div_32
    import mult_div_32_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               div_q, div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               op_signed, op_div;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_adj;
    logic [WIDTH-1:0]   quo_adj, rem_adj;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign a_neg     = op_signed & src_a[WIDTH-1];
    assign b_neg     = op_signed & src_b[WIDTH-1];

    mdu_sign_adj #(.W(WIDTH)) u_abs_a (.val_in(src_a), .neg(a_neg), .val_out(a_abs));
    mdu_sign_adj #(.W(WIDTH)) u_abs_b (.val_in(src_b), .neg(b_neg), .val_out(b_abs));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // Divide: acc = {remainder, dividend/quotient}; candidate remainder is the
    // top WIDTH+1 bits after a left shift, so the MSB of the difference is the borrow.
    assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};

    // Divide by zero keeps the raw all-ones quotient; the remainder then equals
    // |src_a| and the dividend-sign correction restores src_a exactly.
    mdu_sign_adj #(.W(2*WIDTH)) u_fix_prod (
        .val_in(acc_q), .neg(neg_res_q), .val_out(prod_adj));
    mdu_sign_adj #(.W(WIDTH)) u_fix_quo (
        .val_in(acc_q[WIDTH-1:0]), .neg(neg_res_q & (b_q != '0)), .val_out(quo_adj));
    mdu_sign_adj #(.W(WIDTH)) u_fix_rem (
        .val_in(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_rem_q), .val_out(rem_adj));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d     = {{WIDTH{1'b0}}, a_abs};
                    b_d       = b_abs;
                    div_d     = op_div;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    if (hi_we) hi_d = src_a;
                    if (lo_we) lo_d = src_a;
                end
            end
            ST_RUN: begin
                if (div_q) begin
                    if (!div_diff[WIDTH])
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1))
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                if (div_q) begin
                    hi_d = rem_adj;
                    lo_d = quo_adj;
                end else begin
                    {hi_d, lo_d} = prod_adj;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mult_div_32.sv
// Directed bench for mult_div_32 with hand-computed HI/LO results.
module tb_mult_div_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    mult_div_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic with_hi_we);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        hi_we = with_hi_we;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    // Counts busy cycles until done; optionally pokes start/MTHI/MTLO mid-op.
    task automatic wait_done(input string tag, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input int disturb_at);
        int  busy_cnt = 0;
        logic seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (disturb_at != 0 && busy_cnt == disturb_at) begin
                start = 1'b1;
                op    = 2'b11;
                src_a = 32'hDEADBEEF;
                src_b = 32'h00000001;
                hi_we = 1'b1;
                lo_we = 1'b1;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check_eq({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        check_eq({tag, "_busy_cycles"}, busy_cnt, 32'd33);
        check_eq({tag, "_hi"}, hi, exp_hi);
        check_eq({tag, "_lo"}, lo, exp_lo);
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int disturb_at);
        @(negedge clk);
        launch(o, a, b, 1'b0);
        wait_done(tag, exp_hi, exp_lo, disturb_at);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check_eq({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
        check_eq({tag, "_hi_hold"}, hi, exp_hi);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_hi", hi, 32'h0);
        check_eq("rst_lo", lo, 32'h0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;

        do_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        do_op("mult_neg3x5", 2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
        do_op("mult_zero", 2'b00, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 0);
        do_op("mult_m1xm1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0);
        do_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        do_op("div_7dm2", 2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
        do_op("divu_7d2", 2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 0);
        do_op("divu_by0", 2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 0);
        do_op("div_m7by0", 2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);
        do_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);

        // start + MTHI + MTLO mid-op must all be ignored
        do_op("busy_ignore", 2'b01, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 5);

        // MTLO / MTHI in IDLE
        lo_we = 1'b1;
        src_a = 32'h00001234;
        @(negedge clk);
        lo_we = 1'b0;
        check_eq("mtlo_lo", lo, 32'h00001234);
        check_eq("mtlo_hi", hi, 32'h00000000);
        hi_we = 1'b1;
        src_a = 32'hABCD0000;
        @(negedge clk);
        hi_we = 1'b0;
        check_eq("mthi_hi", hi, 32'hABCD0000);
        check_eq("mthi_lo", lo, 32'h00001234);

        // start together with MTHI: write dropped, HI holds until the op lands
        launch(2'b01, 32'h00000003, 32'h00000004, 1'b1);
        check_eq("start_mthi_hold", hi, 32'hABCD0000);
        wait_done("start_mthi", 32'h00000000, 32'h0000000C, 0);

        // back-to-back: second start in the done cycle
        @(negedge clk);
        launch(2'b11, 32'd100, 32'd7, 1'b0);
        wait_done("b2b_a", 32'd2, 32'd14, 0);
        launch(2'b01, 32'h00010000, 32'h00010003, 1'b0);
        check_eq("b2b_busy", {31'b0, busy}, 32'd1);
        wait_done("b2b_b", 32'h00000001, 32'h00030000, 0);

        // async reset in the middle of an op
        @(negedge clk);
        launch(2'b11, 32'd1000, 32'd33, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_hi", hi, 32'h0);
        check_eq("arst_lo", lo, 32'h0);
        check_eq("arst_busy", {31'b0, busy}, 32'd0);
        check_eq("arst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_rst", 2'b11, 32'd1000, 32'd33, 32'd10, 32'd30, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
